dm_write_tracer: RTL and testbench

//  Sits directly downstream of processor_arm, on its data-memory store port (DM_addr/DM_writeData/DM_writeEnable).
//  - Records every data-memory store as an {addr,data} entry in order.
//  - On 'dump', drains the recorded entries through a valid/ready stream, giving a post-run store trace for checking.
//  - Passive: never stalls or alters the processor.

---
 rtl/dm_trace_pkg.sv | 17 +
 rtl/trace_fifo.sv | 61 ++++++
 rtl/dm_write_tracer.sv | 119 +++++++++++
 tb/tb_dm_write_tracer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_trace_pkg.sv
// Shared types for the data-memory store tracer.
package dm_trace_pkg;

    localparam int TRACE_N = 64;

    typedef enum logic [1:0] {
        CAPTURE,
        DRAIN,
        DONE
    } trace_state_t;

    typedef struct packed {
        logic [TRACE_N-1:0] addr;
        logic [TRACE_N-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with occupancy count.
// Read data is taken combinationally from the head and reads as 0 when empty.
module trace_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are only observable while count > 0.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap modulo DEPTH; count disambiguates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dm_write_tracer.sv
// Passive recorder of data-memory stores; drains the recorded trace on a
// rising edge of dump through a valid/ready stream.
module dm_write_tracer
    import dm_trace_pkg::*;
#(
    parameter int N      = 64,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1,
    parameter int DROP_W = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              DM_writeEnable,
    input  logic [N-1:0]      DM_addr,
    input  logic [N-1:0]      DM_writeData,
    input  logic              dump,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_addr,
    output logic [N-1:0]      out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic [DROP_W-1:0] dropped,
    output logic              busy
);

    trace_state_t     state;
    trace_state_t     next_state;
    logic             dump_q;
    logic             dump_rise;
    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [2*N-1:0]   head;

    trace_fifo #(
        .WIDTH (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({DM_addr, DM_writeData}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign dump_rise = dump && !dump_q;
    assign out_addr  = head[2*N-1:N];
    assign out_data  = head[N-1:0];
    assign busy      = (state != CAPTURE);

    // State register and dump edge detector.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state  <= CAPTURE;
            dump_q <= 1'b0;
        end else begin
            state  <= next_state;
            dump_q <= dump;
        end
    end

    // Next-state decode plus push/pop/drop strobes and stream outputs.
    always_comb begin
        next_state = state;
        push       = 1'b0;
        pop        = 1'b0;
        drop       = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        case (state)
            CAPTURE: begin
                push = DM_writeEnable && !full;
                drop = DM_writeEnable && full;
                // A store landing on the dump edge counts toward the drain.
                if (dump_rise) begin
                    next_state = (!empty || push) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                drop      = DM_writeEnable;
                out_valid = !empty;
                out_last  = !empty && (count == CNT_W'(1));
                pop       = out_valid && out_ready;
                if (empty || (pop && out_last)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                drop = DM_writeEnable;
                if (!dump) begin
                    next_state = CAPTURE;
                end
            end
            default: next_state = CAPTURE;
        endcase
    end

    // Sticky overflow flag and saturating dropped-store counter.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            dropped  <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (dropped != '1) begin
                dropped <= dropped + DROP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dm_write_tracer.sv
// Self-checking bench for dm_write_tracer: a directed vector table, directed
// corner sequences and a randomized run against a queue-based trace model.
module tb_dm_write_tracer;

    localparam int N      = 64;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int DROP_W = 16;

    logic              clk;
    logic              reset;
    logic              DM_writeEnable;
    logic [N-1:0]      DM_addr;
    logic [N-1:0]      DM_writeData;
    logic              dump;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_addr;
    logic [N-1:0]      out_data;
    logic              out_last;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [DROP_W-1:0] dropped;
    logic              busy;

    dm_write_tracer #(
        .N      (N),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W),
        .DROP_W (DROP_W)
    ) dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .DM_writeEnable (DM_writeEnable),
        .DM_addr        (DM_addr),
        .DM_writeData   (DM_writeData),
        .dump           (dump),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_addr       (out_addr),
        .out_data       (out_data),
        .out_last       (out_last),
        .count          (count),
        .overflow       (overflow),
        .dropped        (dropped),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: the recorded trace as a queue, plus whether a drain is
    // in progress and whether we are waiting for dump to be released.
    logic [127:0] mq[$];
    bit           m_draining;
    bit           m_waiting;
    bit           m_dump_prev;
    bit           m_ovf;
    int           m_drop;

    task automatic model_reset();
        mq.delete();
        m_draining  = 0;
        m_waiting   = 0;
        m_dump_prev = 0;
        m_ovf       = 0;
        m_drop      = 0;
    endtask

    task automatic model_drop();
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
    endtask

    task automatic check_model(input string tag);
        logic [127:0] hd;
        hd = (mq.size() > 0) ? mq[0] : '0;
        chk({tag, ":valid"},    out_valid, m_draining && mq.size() > 0);
        chk({tag, ":addr"},     out_addr,  hd[127:64]);
        chk({tag, ":data"},     out_data,  hd[63:0]);
        chk({tag, ":last"},     out_last,  m_draining && mq.size() == 1);
        chk({tag, ":count"},    count,     mq.size());
        chk({tag, ":busy"},     busy,      m_draining || m_waiting);
        chk({tag, ":overflow"}, overflow,  m_ovf);
        chk({tag, ":dropped"},  dropped,   m_drop);
    endtask

    // One clock cycle: drive at negedge, check pre-edge outputs, advance model.
    task automatic cycle(input logic we, input logic [63:0] a, input logic [63:0] d,
                         input logic dm, input logic rdy, input string tag);
        DM_writeEnable = we;
        DM_addr        = a;
        DM_writeData   = d;
        dump           = dm;
        out_ready      = rdy;
        #1;
        check_model(tag);
        if (m_draining) begin
            if (we) model_drop();
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (mq.size() == 0) begin
                m_draining = 0;
                m_waiting  = 1;
            end
        end else if (m_waiting) begin
            if (we) model_drop();
            if (!dm) m_waiting = 0;
        end else begin
            if (we) begin
                if (mq.size() < DEPTH) mq.push_back({a, d});
                else model_drop();
            end
            if (dm && !m_dump_prev) begin
                if (mq.size() > 0) m_draining = 1;
                else m_waiting = 1;
            end
        end
        m_dump_prev = dm;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        #2;
        reset          = 1'b0;
        DM_writeEnable = 1'b0;
        dump           = 1'b0;
        out_ready      = 1'b0;
        #1;
        chk({tag, ":rst_valid"},    out_valid, 1'b0);
        chk({tag, ":rst_count"},    count,     0);
        chk({tag, ":rst_addr"},     out_addr,  0);
        chk({tag, ":rst_data"},     out_data,  0);
        chk({tag, ":rst_last"},     out_last,  1'b0);
        chk({tag, ":rst_overflow"}, overflow,  1'b0);
        chk({tag, ":rst_dropped"},  dropped,   0);
        chk({tag, ":rst_busy"},     busy,      1'b0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic        we;
        logic [63:0] a;
        logic [63:0] d;
        logic        dm;
        logic        rdy;
        logic        e_valid;
        logic [63:0] e_addr;
        logic [63:0] e_data;
        logic        e_last;
        int          e_count;
        logic        e_busy;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic dm_r;

        // Three stores, dump, full-rate drain, hold dump, release.
        tbl[0]  = '{1'b1, 64'h8,  64'hA, 1'b0, 1'b1, 1'b0, 64'h0,  64'h0, 1'b0, 0, 1'b0};
        tbl[1]  = '{1'b1, 64'h10, 64'hB, 1'b0, 1'b1, 1'b0, 64'h0,  64'h0, 1'b0, 1, 1'b0};
        tbl[2]  = '{1'b1, 64'h18, 64'hC, 1'b0, 1'b1, 1'b0, 64'h0,  64'h0, 1'b0, 2, 1'b0};
        tbl[3]  = '{1'b0, 64'h0,  64'h0, 1'b1, 1'b1, 1'b0, 64'h0,  64'h0, 1'b0, 3, 1'b0};
        tbl[4]  = '{1'b0, 64'h0,  64'h0, 1'b1, 1'b1, 1'b1, 64'h8,  64'hA, 1'b0, 3, 1'b1};
        tbl[5]  = '{1'b0, 64'h0,  64'h0, 1'b1, 1'b1, 1'b1, 64'h10, 64'hB, 1'b0, 2, 1'b1};
        tbl[6]  = '{1'b0, 64'h0,  64'h0, 1'b1, 1'b1, 1'b1, 64'h18, 64'hC, 1'b1, 1, 1'b1};
        tbl[7]  = '{1'b0, 64'h0,  64'h0, 1'b1, 1'b1, 1'b0, 64'h0,  64'h0, 1'b0, 0, 1'b1};
        tbl[8]  = '{1'b0, 64'h0,  64'h0, 1'b1, 1'b1, 1'b0, 64'h0,  64'h0, 1'b0, 0, 1'b1};
        tbl[9]  = '{1'b0, 64'h0,  64'h0, 1'b0, 1'b1, 1'b0, 64'h0,  64'h0, 1'b0, 0, 1'b1};
        tbl[10] = '{1'b0, 64'h0,  64'h0, 1'b0, 1'b1, 1'b0, 64'h0,  64'h0, 1'b0, 0, 1'b0};

        reset          = 1'b0;
        DM_writeEnable = 1'b0;
        DM_addr        = '0;
        DM_writeData   = '0;
        dump           = 1'b0;
        out_ready      = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            DM_writeEnable = tbl[i].we;
            DM_addr        = tbl[i].a;
            DM_writeData   = tbl[i].d;
            dump           = tbl[i].dm;
            out_ready      = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d:valid", i), out_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d:addr", i), out_addr, tbl[i].e_addr);
                chk($sformatf("tbl%0d:data", i), out_data, tbl[i].e_data);
            end
            chk($sformatf("tbl%0d:last", i),  out_last, tbl[i].e_last);
            chk($sformatf("tbl%0d:count", i), count,    tbl[i].e_count);
            chk($sformatf("tbl%0d:busy", i),  busy,     tbl[i].e_busy);
            @(negedge clk);
        end

        // Reset in the middle of a drain discards everything.
        do_reset("t1a");
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'(i * 8), 64'(i + 5), 1'b0, 1'b0, "t1fill");
        cycle(1'b0, '0, '0, 1'b1, 1'b1, "t1dump");
        cycle(1'b0, '0, '0, 1'b1, 1'b1, "t1pop");
        do_reset("t1b");
        cycle(1'b0, '0, '0, 1'b0, 1'b0, "t1idle");
        cycle(1'b1, 64'h99, 64'h77, 1'b0, 1'b0, "t1store");
        #1;
        chk("t1:count_after_store", count, 1);
        @(negedge clk);

        // Overflow: DEPTH+2 stores, first DEPTH retained and drained in order.
        do_reset("t3");
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b1, 64'(i * 8 + 8), 64'(100 + i), 1'b0, 1'b0, "t3fill");
        chk("t3:count_full", count, DEPTH);
        chk("t3:overflow", overflow, 1'b1);
        chk("t3:dropped", dropped, 2);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, '0, 1'b1, 1'b1, "t3drain");
        cycle(1'b0, '0, '0, 1'b0, 1'b1, "t3rel");

        // Backpressure: ready pattern 1,0,0,1 repeated.
        do_reset("t4");
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'(32 + i), 64'(64'hD0 + i), 1'b0, 1'b0, "t4fill");
        cycle(1'b0, '0, '0, 1'b1, 1'b0, "t4dump");
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, '0, 1'b1, (i % 4 == 0) || (i % 4 == 3), "t4bp");
        cycle(1'b0, '0, '0, 1'b0, 1'b0, "t4rel");

        // Dump with an empty trace goes straight to DONE.
        do_reset("t5");
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b1, "t5hold");
        cycle(1'b0, '0, '0, 1'b0, 1'b1, "t5rel");
        cycle(1'b1, 64'h40, 64'h41, 1'b0, 1'b1, "t5store");
        chk("t5:count_after_store", count, 1);
        chk("t5:busy", busy, 1'b0);

        // Store coincident with dump edge is kept; store during drain is dropped.
        do_reset("t6");
        cycle(1'b1, 64'h100, 64'h1, 1'b0, 1'b0, "t6fill");
        cycle(1'b1, 64'h108, 64'h2, 1'b0, 1'b0, "t6fill");
        cycle(1'b1, 64'h110, 64'h3, 1'b1, 1'b0, "t6coinc");
        chk("t6:count_coinc", count, 3);
        cycle(1'b1, 64'h118, 64'h4, 1'b1, 1'b0, "t6drainst");
        chk("t6:dropped", dropped, 1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'b1, "t6drain");
        cycle(1'b0, '0, '0, 1'b0, 1'b0, "t6rel");

        // Randomized traffic against the model.
        do_reset("rnd");
        dm_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) dm_r = !dm_r;
            cycle($urandom_range(0, 2) == 0, {$urandom, $urandom}, {$urandom, $urandom},
                  dm_r, $urandom_range(0, 3) != 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
